// File: rtl/crtc_reg_ctrl.sv
// CRTC timing register file: CPU address/data access port, masked registers and timing outputs.
// Define CRTC_SHADOW_UPDATE_EN so that writes are applied to the outputs only at the next frame start.
module crtc_reg_ctrl (
    input  logic        sys_clk_i,
    input  logic        reset_n_i,
    input  logic        cs_i,
    input  logic        rs_i,
    input  logic        we_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    input  logic        frame_start_i,
    output logic [7:0]  h_char_total_o,
    output logic [7:0]  h_char_displayed_o,
    output logic [7:0]  h_sync_start_o,
    output logic [3:0]  h_sync_width_o,
    output logic [3:0]  v_sync_width_o,
    output logic [7:0]  v_char_total_o,
    output logic [4:0]  v_adjust_o,
    output logic [7:0]  v_char_displayed_o,
    output logic [7:0]  v_sync_start_o,
    output logic [4:0]  v_char_pixel_size_o,
    output logic [13:0] screen_addr_o,
    output logic        pending_o
);

    localparam int NREG = 14;

    // A zero mask marks an unimplemented register; writes to it are dropped.
    function automatic logic [7:0] reg_mask(input logic [4:0] a);
        case (a)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd8, 5'd13: reg_mask = 8'hFF;
            5'd4, 5'd6, 5'd7:                    reg_mask = 8'h7F;
            5'd5, 5'd9:                          reg_mask = 8'h1F;
            5'd12:                               reg_mask = 8'h3F;
            default:                             reg_mask = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] reg_reset(input logic [3:0] i);
        case (i)
            4'd0:    reg_reset = 8'd49;
            4'd1:    reg_reset = 8'd40;
            4'd2:    reg_reset = 8'd41;
            4'd3:    reg_reset = 8'h0F;
            4'd4:    reg_reset = 8'd32;
            4'd5:    reg_reset = 8'd3;
            4'd6:    reg_reset = 8'd25;
            4'd7:    reg_reset = 8'd29;
            4'd9:    reg_reset = 8'd9;
            4'd12:   reg_reset = 8'h10;
            default: reg_reset = 8'h00;
        endcase
    endfunction

    logic [4:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] active_q [NREG];
    logic [7:0] active_d [NREG];
    logic [7:0] rd12, rd13;
    logic       wr_addr, wr_data;

    assign wr_addr = cs_i && we_i && !rs_i;
    assign wr_data = cs_i && we_i && rs_i && (reg_mask(addr_q) != 8'h00);

`ifdef CRTC_SHADOW_UPDATE_EN
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [0:0] state_q, state_d;
    logic [7:0] shadow_q [NREG];
    logic [7:0] shadow_d [NREG];

    assign rd12 = shadow_q[12];
    assign rd13 = shadow_q[13];

    // The copy uses the pre-write shadow, so a coincident write stays pending.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        state_d  = state_q;
        if (state_q == ST_PENDING && frame_start_i) begin
            active_d = shadow_q;
            state_d  = ST_IDLE;
        end
        if (wr_data) begin
            shadow_d[addr_q[3:0]] = data_i & reg_mask(addr_q);
            state_d               = ST_PENDING;
        end
    end

    always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < NREG; i++) shadow_q[i] <= reg_reset(4'(i));
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
        end
    end

    assign pending_o = (state_q == ST_PENDING);

    logic unused_bits;
    assign unused_bits = ^{active_q[8], active_q[10], active_q[11], active_q[12][7:6], active_q[13]};
`else
    assign rd12 = active_q[12];
    assign rd13 = active_q[13];

    always_comb begin
        active_d = active_q;
        if (wr_data) active_d[addr_q[3:0]] = data_i & reg_mask(addr_q);
    end

    assign pending_o = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{frame_start_i, active_q[8], active_q[10], active_q[11], active_q[12][7:6]};
`endif

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (wr_addr) addr_d = data_i[4:0];
        if (cs_i && !we_i) begin
            if (rs_i && addr_q == 5'd12)      data_d = rd12;
            else if (rs_i && addr_q == 5'd13) data_d = rd13;
            else                              data_d = 8'h00;
        end
    end

    always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_q <= 5'd0;
            data_q <= 8'h00;
            for (int i = 0; i < NREG; i++) active_q[i] <= reg_reset(4'(i));
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            active_q <= active_d;
        end
    end

    assign data_o              = data_q;
    assign h_char_total_o      = active_q[0];
    assign h_char_displayed_o  = active_q[1];
    assign h_sync_start_o      = active_q[2];
    assign h_sync_width_o      = active_q[3][3:0];
    assign v_sync_width_o      = active_q[3][7:4];
    assign v_char_total_o      = {1'b0, active_q[4][6:0]};
    assign v_adjust_o          = active_q[5][4:0];
    assign v_char_displayed_o  = {1'b0, active_q[6][6:0]};
    assign v_sync_start_o      = {1'b0, active_q[7][6:0]};
    assign v_char_pixel_size_o = active_q[9][4:0];
    assign screen_addr_o       = {active_q[12][5:0], active_q[13]};

endmodule

// File: tb/tb_crtc_reg_ctrl.sv
// Directed self-checking bench for crtc_reg_ctrl; expectations follow CRTC_SHADOW_UPDATE_EN when defined.
module tb_crtc_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0, rs = 1'b0, we = 1'b0, frame = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic [7:0]  hct, hcd, hss, vct, vcd, vss;
    logic [3:0]  hsw, vsw;
    logic [4:0]  vadj, vcps;
    logic [13:0] saddr;
    logic        pend;

    int errors = 0;
    int checks = 0;

`ifdef CRTC_SHADOW_UPDATE_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    crtc_reg_ctrl dut (
        .sys_clk_i(clk), .reset_n_i(rst_n), .cs_i(cs), .rs_i(rs), .we_i(we),
        .data_i(din), .data_o(dout), .frame_start_i(frame),
        .h_char_total_o(hct), .h_char_displayed_o(hcd), .h_sync_start_o(hss),
        .h_sync_width_o(hsw), .v_sync_width_o(vsw), .v_char_total_o(vct),
        .v_adjust_o(vadj), .v_char_displayed_o(vcd), .v_sync_start_o(vss),
        .v_char_pixel_size_o(vcps), .screen_addr_o(saddr), .pending_o(pend)
    );

    always #5 clk = ~clk;

    // One-cycle access; returns at the following negedge where outputs are sampled.
    task automatic access(input logic r, input logic w, input logic [7:0] d, input logic fs);
        @(negedge clk);
        cs = 1'b1; rs = r; we = w; din = d; frame = fs;
        @(negedge clk);
        cs = 1'b0; rs = 1'b0; we = 1'b0; din = 8'h00; frame = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout got %h want 00", dout); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL rst_pend got %b want 0", pend); end
        checks++; if (hct !== 8'd49) begin errors++; $display("FAIL rst_hct got %0d want 49", hct); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({hct, hcd, hss, hsw, vsw, vct, vadj, vcd, vss, vcps, saddr, pend, dout} !==
            {8'd49, 8'd40, 8'd41, 4'hF, 4'h0, 8'd32, 5'd3, 8'd25, 8'd29, 5'd9, 14'h1000, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values got hct=%0d hcd=%0d hss=%0d hsw=%h vsw=%h vct=%0d vadj=%0d vcd=%0d vss=%0d vcps=%0d saddr=%h pend=%b dout=%h",
                     hct, hcd, hss, hsw, vsw, vct, vadj, vcd, vss, vcps, saddr, pend, dout);
        end
    endtask

    task automatic test_write_r1();
        access(1'b0, 1'b1, 8'd1, 1'b0);
        access(1'b1, 1'b1, 8'd80, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (pend !== SHADOW) begin errors++; $display("FAIL r1_pend got %b want %b", pend, SHADOW); end
        checks++;
        if (hcd !== (SHADOW ? 8'd40 : 8'd80)) begin errors++; $display("FAIL r1_before_frame got %0d want %0d", hcd, SHADOW ? 40 : 80); end
        pulse_frame();
        checks++; if (hcd !== 8'd80) begin errors++; $display("FAIL r1_after_frame got %0d want 80", hcd); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL r1_pend_clear got %b want 0", pend); end
    endtask

    task automatic test_masking();
        access(1'b0, 1'b1, 8'd4, 1'b0);
        access(1'b1, 1'b1, 8'hFF, 1'b0);
        access(1'b0, 1'b1, 8'd3, 1'b0);
        access(1'b1, 1'b1, 8'hA5, 1'b0);
        access(1'b0, 1'b1, 8'd9, 1'b0);
        access(1'b1, 1'b1, 8'hEE, 1'b0);
        pulse_frame();
        checks++; if (vct !== 8'h7F) begin errors++; $display("FAIL mask_r4 got %h want 7f", vct); end
        checks++; if ({vsw, hsw} !== 8'hA5) begin errors++; $display("FAIL r3_split got %h want a5", {vsw, hsw}); end
        checks++; if (vcps !== 5'h0E) begin errors++; $display("FAIL mask_r9 got %h want 0e", vcps); end
    endtask

    task automatic test_read();
        access(1'b0, 1'b1, 8'd12, 1'b0);
        access(1'b1, 1'b1, 8'hFF, 1'b0);
        access(1'b1, 1'b0, 8'h00, 1'b0);
        checks++; if (dout !== 8'h3F) begin errors++; $display("FAIL read_r12 got %h want 3f", dout); end
        access(1'b0, 1'b1, 8'd13, 1'b0);
        access(1'b1, 1'b1, 8'h34, 1'b0);
        access(1'b1, 1'b0, 8'h00, 1'b0);
        checks++; if (dout !== 8'h34) begin errors++; $display("FAIL read_r13 got %h want 34", dout); end
        repeat (3) @(negedge clk);
        checks++; if (dout !== 8'h34) begin errors++; $display("FAIL read_hold got %h want 34", dout); end
        access(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL read_rs0 got %h want 00", dout); end
        pulse_frame();
        checks++; if (saddr !== 14'h3F34) begin errors++; $display("FAIL screen_addr got %h want 3f34", saddr); end
        access(1'b0, 1'b1, 8'd0, 1'b0);
        access(1'b1, 1'b0, 8'h00, 1'b0);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL read_r0 got %h want 00", dout); end
    endtask

    task automatic test_back_to_back();
        access(1'b0, 1'b1, 8'd0, 1'b0);
        access(1'b1, 1'b1, 8'd55, 1'b0);
        access(1'b1, 1'b1, 8'd60, 1'b1);
        checks++;
        if (hct !== (SHADOW ? 8'd55 : 8'd60)) begin errors++; $display("FAIL coinc_hct got %0d want %0d", hct, SHADOW ? 55 : 60); end
        checks++; if (pend !== SHADOW) begin errors++; $display("FAIL coinc_pend got %b want %b", pend, SHADOW); end
        pulse_frame();
        checks++; if (hct !== 8'd60) begin errors++; $display("FAIL coinc_next got %0d want 60", hct); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL coinc_pend_clear got %b want 0", pend); end
    endtask

    task automatic test_ignored_and_reset();
        access(1'b0, 1'b1, 8'd17, 1'b0);
        access(1'b1, 1'b1, 8'hAA, 1'b0);
        pulse_frame();
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL bad_addr_pend got %b want 0", pend); end
        checks++;
        if ({hct, hcd, vct, saddr} !== {8'd60, 8'd80, 8'h7F, 14'h3F34}) begin
            errors++; $display("FAIL bad_addr_outputs got %h %h %h %h want 3c 50 7f 3f34", hct, hcd, vct, saddr);
        end
        access(1'b0, 1'b1, 8'd1, 1'b0);
        access(1'b1, 1'b1, 8'd99, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pulse_frame();
        checks++;
        if ({hct, hcd, vct, vsw, hsw, vcps, saddr, pend} !== {8'd49, 8'd40, 8'd32, 4'h0, 4'hF, 5'd9, 14'h1000, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got hct=%0d hcd=%0d vct=%0d r3=%h vcps=%0d saddr=%h pend=%b", hct, hcd, vct, {vsw, hsw}, vcps, saddr, pend);
        end
        access(1'b0, 1'b1, 8'd12, 1'b0);
        access(1'b1, 1'b0, 8'h00, 1'b0);
        checks++; if (dout !== 8'h10) begin errors++; $display("FAIL reset_read_r12 got %h want 10", dout); end
    endtask

    initial begin
        test_reset();
        test_write_r1();
        test_masking();
        test_read();
        test_back_to_back();
        test_ignored_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crtc_reg_ctrl.md
CRTC_REG_CTRL -- requirements
Module: crtc_reg_ctrl

Interface
REQ-001 sys_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-002 reset_n_i  in  1  asynchronous, active-low reset.
REQ-003 cs_i  in  1  CPU chip select; one-cycle access strobe.
REQ-004 rs_i  in  1  register select: 0 = address register, 1 = data register.
REQ-005 we_i  in  1  1 = write, 0 = read, qualified by cs_i.
REQ-006 data_i  in  8  CPU write data.
REQ-007 data_o  out  8  CPU read data, registered.
REQ-008 frame_start_i  in  1  one-cycle pulse from the sync generator at frame start.
REQ-009 h_char_total_o  out  8  active R0.
REQ-010 h_char_displayed_o  out  8  active R1.
REQ-011 h_sync_start_o  out  8  active R2.
REQ-012 h_sync_width_o  out  4  active R3[3:0].
REQ-013 v_sync_width_o  out  4  active R3[7:4].
REQ-014 v_char_total_o  out  8  active R4[6:0], zero-extended.
REQ-015 v_adjust_o  out  5  active R5[4:0].
REQ-016 v_char_displayed_o  out  8  active R6[6:0], zero-extended.
REQ-017 v_sync_start_o  out  8  active R7[6:0], zero-extended.
REQ-018 v_char_pixel_size_o  out  5  active R9[4:0].
REQ-019 screen_addr_o  out  14  active {R12[5:0], R13}.
REQ-020 pending_o  out  1  shadow holds writes not yet applied.

Function
REQ-021 Write with cs_i=1, we_i=1, rs_i=0 SHALL load data_i[4:0] into the 5-bit address register.
REQ-022 Write with rs_i=1 SHALL load data_i into shadow register [address] when the address is in {0-9, 12, 13}; unimplemented bits SHALL be masked to 0; other addresses SHALL be ignored.
REQ-023 Read with rs_i=1 SHALL return shadow R12 or R13 on data_o the following cycle; all other addresses, and reads with rs_i=0, SHALL return 8'h00.
REQ-024 data_o SHALL hold its value when there is no read access.
REQ-025 Two-state FSM: IDLE (pending_o=0) and PENDING (pending_o=1).
REQ-026 IDLE -> PENDING on any accepted data write.
REQ-027 PENDING -> IDLE on frame_start_i, which copies all shadow registers to the active registers in that same edge.
REQ-028 A data write and frame_start_i on the same edge SHALL copy the pre-write shadow to active, apply the write to the shadow, and leave the FSM in PENDING.
REQ-029 frame_start_i in IDLE SHALL have no effect.
REQ-030 All outputs SHALL be driven directly from registers, with no combinational path from inputs.
REQ-031 R8 is stored and readable internally only; it is not output.

Reset
REQ-032 While reset_n_i=0: the FSM is IDLE, the address register is 0, and data_o=0.
REQ-033 While reset_n_i=0, shadow and active registers are R0=49, R1=40, R2=41, R3=8'h0F, R4=32, R5=3, R6=25, R7=29, R8=0, R9=9, R12=8'h10, R13=0.
REQ-034 Reset asserted mid-PENDING SHALL discard unapplied writes.

Configuration
REQ-035 Macro CRTC_SHADOW_UPDATE_EN defined: shadow/active double buffering applies per REQ-025 to REQ-029.
REQ-036 Macro CRTC_SHADOW_UPDATE_EN undefined: data writes update the active registers on the same edge; the FSM is removed; pending_o is tied to 0; frame_start_i is ignored.

Verification
REQ-037 Release reset, idle 10 cycles -> outputs equal REQ-033 values, for example h_char_total_o=49 and screen_addr_o=14'h1000.
REQ-038 Write addr=1 then data=8'd80 -> pending_o=1 and h_char_displayed_o stays 40 until the frame_start_i pulse, then becomes 80 with pending_o=0.
REQ-039 Write addr=4 then data=8'hFF -> after frame_start_i, v_char_total_o=8'h7F.
REQ-040 Write addr=12 data=8'hFF, then read data -> data_o=8'h3F; read addr=0 -> data_o=8'h00.
REQ-041 Data write to R0 of 60 coincident with frame_start_i, after an earlier R0 write of 55 -> h_char_total_o=55 and pending_o=1; the next frame_start_i gives 60.
REQ-042 Write addr=17 then data=8'hAA -> no change in pending_o or any output; pulse reset_n_i low during PENDING -> outputs equal REQ-033 values.
